// File: rtl/alu_arbiter.sv
// Two-requester front end for one shared 4-bit ALU: grants one operation at a time, runs it, and holds the result until taken.
// Optional build macro ALU_ARB_FIXED_PRIO_EN selects fixed priority (requester 0 first) instead of round-robin.
module alu_arbiter #(
    parameter int EXEC_CYCLES = 1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] req_valid,
    output logic [1:0] req_ready,
    input  logic [5:0] req_op,
    input  logic [7:0] req_a,
    input  logic [7:0] req_b,
    output logic [1:0] rsp_valid,
    input  logic [1:0] rsp_ready,
    output logic [3:0] rsp_res,
    output logic [2:0] rsp_flags,
    output logic [2:0] alu_fnselec,
    output logic [3:0] alu_a,
    output logic [3:0] alu_b,
    input  logic [3:0] alu_res,
    input  logic       alu_carry,
    input  logic       alu_overflow,
    input  logic       alu_zero,
    output logic       busy
);

    typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

    localparam logic [3:0] LAST_CNT = 4'(EXEC_CYCLES - 1);

    state_t     state;
    logic [3:0] cnt;
    logic       gnt;
    logic       grant_sel;
`ifndef ALU_ARB_FIXED_PRIO_EN
    logic       last;
`endif

    // grant_sel: index of the requester that wins if a grant happens this cycle
    always_comb begin
        grant_sel = 1'b0;
`ifdef ALU_ARB_FIXED_PRIO_EN
        grant_sel = ~req_valid[0];
`else
        if (req_valid == 2'b11)
            grant_sel = ~last;
        else
            grant_sel = req_valid[1];
`endif
    end

    // Acceptance is combinational so the handshake completes in the grant cycle; held low during reset.
    always_comb begin
        req_ready = 2'b00;
        if (rst_n && state == IDLE && |req_valid)
            req_ready = grant_sel ? 2'b10 : 2'b01;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            cnt         <= 4'd0;
            gnt         <= 1'b0;
`ifndef ALU_ARB_FIXED_PRIO_EN
            last        <= 1'b1;
`endif
            rsp_valid   <= 2'b00;
            rsp_res     <= 4'd0;
            rsp_flags   <= 3'd0;
            alu_fnselec <= 3'd0;
            alu_a       <= 4'd0;
            alu_b       <= 4'd0;
            busy        <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (|req_valid) begin
                        gnt         <= grant_sel;
                        alu_fnselec <= grant_sel ? req_op[5:3] : req_op[2:0];
                        alu_a       <= grant_sel ? req_a[7:4]  : req_a[3:0];
                        alu_b       <= grant_sel ? req_b[7:4]  : req_b[3:0];
                        cnt         <= 4'd0;
                        busy        <= 1'b1;
                        state       <= EXEC;
                    end
                end
                EXEC: begin
                    if (cnt == LAST_CNT) begin
                        rsp_res   <= alu_res;
                        rsp_flags <= {alu_carry, alu_overflow, alu_zero};
                        rsp_valid <= gnt ? 2'b10 : 2'b01;
                        cnt       <= 4'd0;
                        state     <= RESP;
                    end else begin
                        cnt <= cnt + 4'd1;
                    end
                end
                RESP: begin
                    // only the granted requester's rsp_ready completes the transaction
                    if (rsp_ready[gnt]) begin
                        rsp_valid   <= 2'b00;
                        alu_fnselec <= 3'd0;
                        alu_a       <= 4'd0;
                        alu_b       <= 4'd0;
                        busy        <= 1'b0;
`ifndef ALU_ARB_FIXED_PRIO_EN
                        last        <= gnt;
`endif
                        state       <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_arbiter.sv
// Self-checking bench for alu_arbiter: directed scenarios plus a randomized run against a cycle-count transaction model.
// Honours ALU_ARB_FIXED_PRIO_EN the same way the design does.
module tb_alu_arbiter;

    logic       clk;
    logic       rst_n;
    logic [1:0] req_valid, req_ready, rsp_valid, rsp_ready;
    logic [5:0] req_op;
    logic [7:0] req_a, req_b;
    logic [3:0] rsp_res, alu_a, alu_b, alu_res;
    logic [2:0] rsp_flags, alu_fnselec;
    logic       alu_carry, alu_overflow, alu_zero, busy;

    logic [1:0] req_valid3, req_ready3, rsp_valid3, rsp_ready3;
    logic [5:0] req_op3;
    logic [7:0] req_a3, req_b3;
    logic [3:0] rsp_res3, alu_a3, alu_b3, alu_res3;
    logic [2:0] rsp_flags3, alu_fnselec3;
    logic       alu_carry3, alu_overflow3, alu_zero3, busy3;

    int n_cmp = 0;
    int n_fail = 0;

    localparam int EC1 = 1;

    // Environment ALU: returns {res[3:0], carry, overflow, zero}
    function automatic logic [6:0] alu_f(input logic [2:0] op, input logic [3:0] a, input logic [3:0] b);
        logic [4:0] w;
        logic [3:0] r;
        logic c, v;
        w = 5'd0; r = 4'd0; c = 1'b0; v = 1'b0;
        case (op)
            3'd0: begin w = {1'b0, a} + {1'b0, b}; r = w[3:0]; c = w[4]; v = (a[3] == b[3]) && (r[3] != a[3]); end
            3'd1: begin w = {1'b0, a} - {1'b0, b}; r = w[3:0]; c = w[4]; v = (a[3] != b[3]) && (r[3] != a[3]); end
            3'd2: r = a & b;
            3'd3: r = a | b;
            3'd4: r = a ^ b;
            3'd5: r = ~a;
            3'd6: begin r = {a[2:0], 1'b0}; c = a[3]; end
            default: begin r = {1'b0, a[3:1]}; c = a[0]; end
        endcase
        return {r, c, v, (r == 4'd0)};
    endfunction

    // Winner when both are pending follows the previous completed grant; a lone request always wins.
    function automatic logic pick(input logic [1:0] v, input logic prev);
`ifdef ALU_ARB_FIXED_PRIO_EN
        return !v[0];
`else
        if (v == 2'b11) return !prev;
        return v[1];
`endif
    endfunction

    assign {alu_res, alu_carry, alu_overflow, alu_zero}     = alu_f(alu_fnselec, alu_a, alu_b);
    assign {alu_res3, alu_carry3, alu_overflow3, alu_zero3} = alu_f(alu_fnselec3, alu_a3, alu_b3);

    alu_arbiter #(.EXEC_CYCLES(EC1)) dut (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
        .req_op(req_op), .req_a(req_a), .req_b(req_b), .rsp_valid(rsp_valid),
        .rsp_ready(rsp_ready), .rsp_res(rsp_res), .rsp_flags(rsp_flags),
        .alu_fnselec(alu_fnselec), .alu_a(alu_a), .alu_b(alu_b), .alu_res(alu_res),
        .alu_carry(alu_carry), .alu_overflow(alu_overflow), .alu_zero(alu_zero), .busy(busy)
    );

    alu_arbiter #(.EXEC_CYCLES(3)) dut3 (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid3), .req_ready(req_ready3),
        .req_op(req_op3), .req_a(req_a3), .req_b(req_b3), .rsp_valid(rsp_valid3),
        .rsp_ready(rsp_ready3), .rsp_res(rsp_res3), .rsp_flags(rsp_flags3),
        .alu_fnselec(alu_fnselec3), .alu_a(alu_a3), .alu_b(alu_b3), .alu_res(alu_res3),
        .alu_carry(alu_carry3), .alu_overflow(alu_overflow3), .alu_zero(alu_zero3), .busy(busy3)
    );

    always #5 clk = ~clk;

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic clear_inputs();
        req_valid = 2'b00; rsp_ready = 2'b00; req_op = 6'd0; req_a = 8'd0; req_b = 8'd0;
        req_valid3 = 2'b00; rsp_ready3 = 2'b00; req_op3 = 6'd0; req_a3 = 8'd0; req_b3 = 8'd0;
    endtask

    // Leaves the bench 1 time unit after a rising edge with reset released.
    task automatic do_reset();
        clear_inputs();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    task automatic test_reset();
        logic [31:0] got;
        clear_inputs();
        rst_n = 1'b0;
        req_valid = 2'b11; req_valid3 = 2'b11; rsp_ready = 2'b11;
        #3;
        got = {req_ready, rsp_valid, rsp_res, rsp_flags, alu_fnselec, alu_a, alu_b, busy, req_ready3, rsp_valid3, busy3};
        n_cmp++;
        if (got !== 32'd0) begin
            n_fail++;
            $display("FAIL reset_async_outputs got %h want 0", got);
        end
        @(posedge clk); #1;
        got = {req_ready, rsp_valid, rsp_res, rsp_flags, alu_fnselec, alu_a, alu_b, busy};
        n_cmp++;
        if (got !== 32'd0) begin
            n_fail++;
            $display("FAIL reset_held_outputs got %h want 0", got);
        end
        do_reset();
    endtask

    task automatic test_basic();
        do_reset();
        req_valid = 2'b01; req_op = 6'd0; req_a = 8'h03; req_b = 8'h04;
        @(negedge clk);
        n_cmp++;
        if ({req_ready, busy} !== {2'b01, 1'b0}) begin
            n_fail++;
            $display("FAIL basic_accept got ready=%b busy=%b want ready=01 busy=0", req_ready, busy);
        end
        @(posedge clk); #1 req_valid = 2'b00;
        @(negedge clk);
        n_cmp++;
        if ({rsp_valid, busy, alu_fnselec, alu_a, alu_b} !== {2'b00, 1'b1, 3'd0, 4'd3, 4'd4}) begin
            n_fail++;
            $display("FAIL basic_exec got valid=%b busy=%b fn=%0d a=%0d b=%0d want 00 1 0 3 4",
                     rsp_valid, busy, alu_fnselec, alu_a, alu_b);
        end
        @(posedge clk); #1;
        @(negedge clk);
        n_cmp++;
        if ({rsp_valid, rsp_res, rsp_flags} !== {2'b01, 4'd7, 3'b000}) begin
            n_fail++;
            $display("FAIL basic_resp got valid=%b res=%0d flags=%b want 01 7 000", rsp_valid, rsp_res, rsp_flags);
        end
        rsp_ready = 2'b01;
        @(posedge clk); #1 rsp_ready = 2'b00;
        @(negedge clk);
        n_cmp++;
        if ({rsp_valid, busy, rsp_res, alu_a, alu_b} !== {2'b00, 1'b0, 4'd7, 4'd0, 4'd0}) begin
            n_fail++;
            $display("FAIL basic_after got valid=%b busy=%b res=%0d a=%0d b=%0d want 00 0 7 0 0",
                     rsp_valid, busy, rsp_res, alu_a, alu_b);
        end
    endtask

    task automatic test_round_robin();
        logic       exp_g, cur_g;
        logic [6:0] cur_exp;
        int         ngrant;
        do_reset();
        req_valid = 2'b11; rsp_ready = 2'b11;
        exp_g = 1'b0; cur_g = 1'b0; cur_exp = 7'd0; ngrant = 0;
        for (int cyc = 0; cyc < 30 && ngrant < 4; cyc++) begin
            req_op = 6'($urandom); req_a = 8'($urandom); req_b = 8'($urandom);
            @(negedge clk);
            if (req_ready != 2'b00) begin
                n_cmp++;
                if (req_ready !== (exp_g ? 2'b10 : 2'b01)) begin
                    n_fail++;
                    $display("FAIL rr_grant%0d got %b want %b", ngrant, req_ready, exp_g ? 2'b10 : 2'b01);
                end
                cur_g = exp_g;
                cur_exp = exp_g ? alu_f(req_op[5:3], req_a[7:4], req_b[7:4]) : alu_f(req_op[2:0], req_a[3:0], req_b[3:0]);
                ngrant++;
`ifndef ALU_ARB_FIXED_PRIO_EN
                exp_g = !exp_g;
`endif
            end
            if (rsp_valid != 2'b00) begin
                n_cmp++;
                if ({rsp_valid, rsp_res, rsp_flags} !== {(cur_g ? 2'b10 : 2'b01), cur_exp}) begin
                    n_fail++;
                    $display("FAIL rr_resp got valid=%b res=%h flags=%b want valid=%b res=%h flags=%b",
                             rsp_valid, rsp_res, rsp_flags, cur_g ? 2'b10 : 2'b01, cur_exp[6:3], cur_exp[2:0]);
                end
            end
            @(posedge clk); #1;
        end
        n_cmp++;
        if (ngrant != 4) begin
            n_fail++;
            $display("FAIL rr_grant_count got %0d want 4", ngrant);
        end
    endtask

    task automatic test_backpressure();
        do_reset();
        req_valid = 2'b01; req_op = 6'd0; req_a = 8'h09; req_b = 8'h08;
        @(negedge clk);
        n_cmp++;
        if (req_ready !== 2'b01) begin
            n_fail++;
            $display("FAIL bp_accept got %b want 01", req_ready);
        end
        @(posedge clk); #1 req_valid = 2'b11; rsp_ready = 2'b10;
        @(negedge clk);
        n_cmp++;
        if (req_ready !== 2'b00) begin
            n_fail++;
            $display("FAIL bp_exec_ready got %b want 00", req_ready);
        end
        @(posedge clk); #1;
        for (int k = 0; k < 6; k++) begin
            if (k == 5) rsp_ready = 2'b01;
            @(negedge clk);
            n_cmp++;
            if ({rsp_valid, rsp_res, rsp_flags, req_ready} !== {2'b01, 4'd1, 3'b110, 2'b00}) begin
                n_fail++;
                $display("FAIL bp_hold%0d got valid=%b res=%0d flags=%b ready=%b want 01 1 110 00",
                         k, rsp_valid, rsp_res, rsp_flags, req_ready);
            end
            @(posedge clk); #1;
        end
        rsp_ready = 2'b00;
        @(negedge clk);
        n_cmp++;
`ifdef ALU_ARB_FIXED_PRIO_EN
        if ({req_ready, rsp_valid, rsp_res} !== {2'b01, 2'b00, 4'd1}) begin
`else
        if ({req_ready, rsp_valid, rsp_res} !== {2'b10, 2'b00, 4'd1}) begin
`endif
            n_fail++;
            $display("FAIL bp_next_grant got ready=%b valid=%b res=%0d", req_ready, rsp_valid, rsp_res);
        end
        @(posedge clk); #1 req_valid = 2'b00;
    endtask

    task automatic test_exec_cycles();
        logic [6:0] e;
        do_reset();
        req_valid3 = 2'b01; req_op3 = {3'd0, 3'($urandom)}; req_a3 = 8'($urandom); req_b3 = 8'($urandom);
        e = alu_f(req_op3[2:0], req_a3[3:0], req_b3[3:0]);
        @(negedge clk);
        n_cmp++;
        if ({req_ready3, busy3} !== {2'b01, 1'b0}) begin
            n_fail++;
            $display("FAIL ec3_accept got ready=%b busy=%b want 01 0", req_ready3, busy3);
        end
        @(posedge clk); #1 req_valid3 = 2'b00;
        for (int k = 1; k <= 3; k++) begin
            @(negedge clk);
            n_cmp++;
            if ({rsp_valid3, busy3} !== {2'b00, 1'b1}) begin
                n_fail++;
                $display("FAIL ec3_exec%0d got valid=%b busy=%b want 00 1", k, rsp_valid3, busy3);
            end
            @(posedge clk); #1;
        end
        @(negedge clk);
        n_cmp++;
        if ({rsp_valid3, busy3, rsp_res3, rsp_flags3} !== {2'b01, 1'b1, e}) begin
            n_fail++;
            $display("FAIL ec3_resp got valid=%b busy=%b res=%h flags=%b want 01 1 %h %b",
                     rsp_valid3, busy3, rsp_res3, rsp_flags3, e[6:3], e[2:0]);
        end
        rsp_ready3 = 2'b01;
        @(posedge clk); #1 rsp_ready3 = 2'b00;
        @(negedge clk);
        n_cmp++;
        if ({rsp_valid3, busy3} !== {2'b00, 1'b0}) begin
            n_fail++;
            $display("FAIL ec3_done got valid=%b busy=%b want 00 0", rsp_valid3, busy3);
        end
    endtask

    task automatic test_reset_midflight();
        logic [31:0] got;
        do_reset();
        req_valid = 2'b01; rsp_ready = 2'b01; req_op = 6'd0; req_a = 8'h21; req_b = 8'h11;
        @(posedge clk); #1 req_valid = 2'b00;
        repeat (2) @(posedge clk);
        #1 req_valid = 2'b10; rsp_ready = 2'b00; req_op = 6'o30; req_a = 8'h50; req_b = 8'h60;
        @(negedge clk);
        n_cmp++;
        if (req_ready !== 2'b10) begin
            n_fail++;
            $display("FAIL mid_accept got %b want 10", req_ready);
        end
        @(posedge clk); #1 req_valid = 2'b00;
        #2 rst_n = 1'b0;
        #1;
        got = {req_ready, rsp_valid, rsp_res, rsp_flags, alu_fnselec, alu_a, alu_b, busy};
        n_cmp++;
        if (got !== 32'd0) begin
            n_fail++;
            $display("FAIL mid_reset_outputs got %h want 0", got);
        end
        @(posedge clk); #1 rst_n = 1'b1; rsp_ready = 2'b11;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            n_cmp++;
            if ({rsp_valid, busy} !== {2'b00, 1'b0}) begin
                n_fail++;
                $display("FAIL mid_no_resp%0d got valid=%b busy=%b want 00 0", k, rsp_valid, busy);
            end
            @(posedge clk); #1;
        end
        req_valid = 2'b11;
        @(negedge clk);
        n_cmp++;
        if (req_ready !== 2'b01) begin
            n_fail++;
            $display("FAIL mid_tie_grant got %b want 01", req_ready);
        end
        @(posedge clk); #1 req_valid = 2'b00;
    endtask

    task automatic test_random();
        logic        m_busy, m_last, m_g;
        int          m_t;
        logic [2:0]  m_op, m_flags;
        logic [3:0]  m_a, m_b, m_res;
        logic [6:0]  m_exp;
        logic [1:0]  e_ready, e_valid;
        logic [25:0] exp_v, got_v;
        do_reset();
        m_busy = 1'b0; m_last = 1'b1; m_g = 1'b0; m_t = 0;
        m_op = 3'd0; m_a = 4'd0; m_b = 4'd0; m_res = 4'd0; m_flags = 3'd0; m_exp = 7'd0;
        for (int cyc = 0; cyc < 500; cyc++) begin
            req_valid = 2'($urandom_range(0, 3)); rsp_ready = 2'($urandom_range(0, 3));
            req_op = 6'($urandom); req_a = 8'($urandom); req_b = 8'($urandom);
            @(negedge clk);
            e_ready = 2'b00;
            if (!m_busy && req_valid != 2'b00) e_ready = pick(req_valid, m_last) ? 2'b10 : 2'b01;
            e_valid = (m_busy && m_t >= EC1 + 1) ? (m_g ? 2'b10 : 2'b01) : 2'b00;
            exp_v = {e_ready, e_valid, m_busy, m_res, m_flags,
                     (m_busy ? m_op : 3'd0), (m_busy ? m_a : 4'd0), (m_busy ? m_b : 4'd0)};
            got_v = {req_ready, rsp_valid, busy, rsp_res, rsp_flags, alu_fnselec, alu_a, alu_b};
            n_cmp++;
            if (got_v !== exp_v) begin
                n_fail++;
                $display("FAIL rand_cycle%0d got %h want %h (ready,valid,busy,res,flags,fn,a,b)", cyc, got_v, exp_v);
            end
            if (!m_busy) begin
                if (req_valid != 2'b00) begin
                    m_g  = pick(req_valid, m_last);
                    m_op = m_g ? req_op[5:3] : req_op[2:0];
                    m_a  = m_g ? req_a[7:4]  : req_a[3:0];
                    m_b  = m_g ? req_b[7:4]  : req_b[3:0];
                    m_exp = alu_f(m_op, m_a, m_b);
                    m_busy = 1'b1; m_t = 1;
                end
            end else if (m_t >= EC1 + 1) begin
                if (rsp_ready[m_g]) begin
                    m_busy = 1'b0; m_last = m_g;
                end
            end else begin
                m_t++;
                if (m_t == EC1 + 1) {m_res, m_flags} = m_exp;
            end
            @(posedge clk); #1;
        end
        clear_inputs();
    endtask

    initial begin
        clk = 1'b0;
        rst_n = 1'b0;
        clear_inputs();
        test_reset();
        test_basic();
        test_round_robin();
        test_backpressure();
        test_exec_cycles();
        test_reset_midflight();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
